// File: rtl/orv64_typedef_pkg.sv
// Shared ORV64 front-end types: fetch-to-align and align-to-decode bundles,
// plus the parcel entry held inside the alignment queue.
package orv64_typedef_pkg;

    localparam int ORV64_PARCEL_WIDTH     = 16;
    localparam int ORV64_PC_WIDTH         = 39;
    localparam int ORV64_EXCP_CAUSE_WIDTH = 4;

    typedef logic [ORV64_PARCEL_WIDTH-1:0] orv64_parcel_t;

    typedef struct packed {
        logic [31:0]                       data;
        logic [ORV64_PC_WIDTH-1:0]         pc;
        logic                              excp_valid;
        logic [ORV64_EXCP_CAUSE_WIDTH-1:0] excp_cause;
    } orv64_ib2align_t;

    typedef struct packed {
        logic [31:0]                       inst;
        logic                              is_rvc;
        logic [ORV64_PC_WIDTH-1:0]         pc;
        logic                              excp_valid;
        logic [ORV64_EXCP_CAUSE_WIDTH-1:0] excp_cause;
        logic [ORV64_PC_WIDTH-1:0]         excp_tval;
    } orv64_align2id_t;

    typedef struct packed {
        orv64_parcel_t                     data;
        logic                              excp;
        logic [ORV64_EXCP_CAUSE_WIDTH-1:0] cause;
    } orv64_parcel_entry_t;

    typedef enum logic {
        ALIGN_RUN       = 1'b0,
        ALIGN_EXCP_HOLD = 1'b1
    } orv64_align_state_e;

    // Anything other than 2'b11 in the low bits is a compressed encoding.
    function automatic logic is_rvc_parcel(input orv64_parcel_t p);
        return p[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/orv64_parcel_queue.sv
// Four-entry shifting parcel FIFO: pops 0/1/2 from the head, then appends 0/1/2 behind
// the survivors in the same cycle. No internal flow control; the caller guarantees room.
module orv64_parcel_queue
    import orv64_typedef_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [1:0]                push_cnt,
    input  orv64_parcel_entry_t [1:0] push_entry,
    input  logic [1:0]                pop_cnt,
    output orv64_parcel_entry_t [1:0] head,
    output logic [2:0]                count
);

    localparam int ENTRY_W = $bits(orv64_parcel_entry_t);

    orv64_parcel_entry_t [3:0] q;
    orv64_parcel_entry_t [3:0] q_next;
    logic [2:0]                base;
    logic [2:0]                count_next;

    always_comb begin
        q_next = q >> (ENTRY_W * int'(pop_cnt));
        base   = count - {1'b0, pop_cnt};
        if (push_cnt != 2'd0) begin
            q_next[base[1:0]] = push_entry[0];
        end
        if (push_cnt == 2'd2) begin
            q_next[base[1:0] + 2'd1] = push_entry[1];
        end
        count_next = base + {1'b0, push_cnt};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            count <= 3'd0;
        end else if (flush) begin
            q     <= '0;
            count <= 3'd0;
        end else begin
            q     <= q_next;
            count <= count_next;
        end
    end

    assign head = q[1:0];

endmodule

// File: rtl/orv64_inst_align.sv
// Re-aligns 32-bit fetch chunks into one RVC or 32-bit instruction per cycle, in order with faults.
// Chunk-to-output latency 1 cycle; in_ready needs <=2 held parcels, an exception holds until flush.
module orv64_inst_align
    import orv64_typedef_pkg::*;
#(
    parameter int PC_WIDTH         = ORV64_PC_WIDTH,
    parameter int NUM_PARCELS      = 4,
    parameter int EXCP_CAUSE_WIDTH = ORV64_EXCP_CAUSE_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_data,
    input  logic [PC_WIDTH-1:0]         in_pc,
    input  logic                        in_excp_valid,
    input  logic [EXCP_CAUSE_WIDTH-1:0] in_excp_cause,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_inst,
    output logic                        out_is_rvc,
    output logic [PC_WIDTH-1:0]         out_pc,
    output logic                        out_excp_valid,
    output logic [EXCP_CAUSE_WIDTH-1:0] out_excp_cause,
    output logic [PC_WIDTH-1:0]         out_excp_tval,
    output logic                        align_idle
);

    orv64_ib2align_t           ib;
    orv64_align2id_t           id;
    orv64_parcel_entry_t [1:0] head;
    orv64_parcel_entry_t [1:0] push_entry;
    orv64_align_state_e        state_q;
    orv64_align_state_e        state_d;
    logic [PC_WIDTH-1:0]       head_pc_q;
    logic [PC_WIDTH-1:0]       head_pc_d;
    logic [2:0]                count;
    logic [1:0]                push_cnt;
    logic [1:0]                pop_len;
    logic [1:0]                pop_cnt;
    logic                      accept;
    logic                      fire;
    logic                      inst_vld;

    assign ib = '{data: in_data, pc: in_pc, excp_valid: in_excp_valid, excp_cause: in_excp_cause};

    // Registered count only: a same-cycle pop never opens the input.
    assign in_ready = (count <= 3'(NUM_PARCELS - 2)) && (state_q == ALIGN_RUN) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        push_cnt      = 2'd0;
        push_entry[0] = '{data: ib.data[15:0],  excp: ib.excp_valid, cause: ib.excp_cause};
        push_entry[1] = '{data: ib.data[31:16], excp: ib.excp_valid, cause: ib.excp_cause};
        if (accept) begin
            push_cnt = ib.pc[1] ? 2'd1 : 2'd2;
            if (ib.pc[1]) begin
                push_entry[0].data = ib.data[31:16];
            end
        end
    end

    orv64_parcel_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_cnt   (push_cnt),
        .push_entry (push_entry),
        .pop_cnt    (pop_cnt),
        .head       (head),
        .count      (count)
    );

    // A faulting head is reported before any length check; a 32-bit head waits for its upper half.
    always_comb begin
        id       = '0;
        inst_vld = 1'b0;
        pop_len  = 2'd0;
        if (state_q == ALIGN_RUN && count != 3'd0) begin
            if (head[0].excp) begin
                inst_vld      = 1'b1;
                id.pc         = head_pc_q;
                id.excp_valid = 1'b1;
                id.excp_cause = head[0].cause;
                id.excp_tval  = head_pc_q;
            end else if (is_rvc_parcel(head[0].data)) begin
                inst_vld  = 1'b1;
                id.pc     = head_pc_q;
                id.inst   = {16'h0000, head[0].data};
                id.is_rvc = 1'b1;
                pop_len   = 2'd1;
            end else if (count >= 3'd2) begin
                inst_vld = 1'b1;
                id.pc    = head_pc_q;
                if (head[1].excp) begin
                    id.excp_valid = 1'b1;
                    id.excp_cause = head[1].cause;
                    id.excp_tval  = head_pc_q + PC_WIDTH'(2);
                end else begin
                    id.inst = {head[1].data, head[0].data};
                    pop_len = 2'd2;
                end
            end
        end
    end

    assign fire    = inst_vld && out_ready && !flush;
    assign pop_cnt = fire ? pop_len : 2'd0;

    always_comb begin
        state_d   = state_q;
        head_pc_d = head_pc_q;
        if (flush) begin
            state_d = ALIGN_RUN;
        end else begin
            if (fire && id.excp_valid) begin
                state_d = ALIGN_EXCP_HOLD;
            end
            if (accept && count == 3'd0) begin
                head_pc_d = ib.pc;
            end else if (pop_cnt != 2'd0) begin
                head_pc_d = head_pc_q + PC_WIDTH'({pop_cnt, 1'b0});
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ALIGN_RUN;
            head_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            head_pc_q <= head_pc_d;
        end
    end

    assign out_valid      = inst_vld;
    assign out_inst       = id.inst;
    assign out_is_rvc     = id.is_rvc;
    assign out_pc         = id.pc;
    assign out_excp_valid = id.excp_valid;
    assign out_excp_cause = id.excp_cause;
    assign out_excp_tval  = id.excp_tval;
    assign align_idle     = (count == 3'd0) && (state_q == ALIGN_RUN);

    // Upstream must deliver a gap-free parcel stream while anything is held.
    logic [PC_WIDTH-1:0] chunk_base;
    logic [PC_WIDTH-1:0] expect_base;
    assign chunk_base  = {ib.pc[PC_WIDTH-1:2], 1'b0, ib.pc[0]};
    assign expect_base = head_pc_q + PC_WIDTH'({count, 1'b0});

    a_contiguous: assert property (@(posedge clk) disable iff (rst)
        (accept && count != 3'd0) |-> (chunk_base == expect_base));

endmodule

// File: tb/tb_orv64_inst_align.sv
// Directed scenarios plus a random stream, all checked against a parcel-list reference model.
module tb_orv64_inst_align;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [38:0] in_pc = '0;
    logic        in_excp_valid = 1'b0;
    logic [3:0]  in_excp_cause = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_is_rvc;
    logic [38:0] out_pc;
    logic        out_excp_valid;
    logic [3:0]  out_excp_cause;
    logic [38:0] out_excp_tval;
    logic        align_idle;

    always #5 clk = ~clk;

    orv64_inst_align dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_pc          (in_pc),
        .in_excp_valid  (in_excp_valid),
        .in_excp_cause  (in_excp_cause),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_is_rvc     (out_is_rvc),
        .out_pc         (out_pc),
        .out_excp_valid (out_excp_valid),
        .out_excp_cause (out_excp_cause),
        .out_excp_tval  (out_excp_tval),
        .align_idle     (align_idle)
    );

    // Reference model: ordered list of held parcels, each carrying its own address.
    typedef struct {
        logic [15:0] data;
        logic        excp;
        logic [3:0]  cause;
        logic [38:0] pc;
    } mparcel_t;

    mparcel_t    mq[$];
    bit          m_hold = 1'b0;
    bit          e_valid, e_excp, e_rvc, e_in_ready, e_idle;
    int          e_pop;
    logic [31:0] e_inst;
    logic [38:0] e_pc, e_tval;
    logic [3:0]  e_cause;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_expect();
        e_valid = 0; e_excp = 0; e_rvc = 0; e_pop = 0;
        e_inst = '0; e_pc = '0; e_tval = '0; e_cause = '0;
        e_in_ready = (mq.size() <= 2) && !m_hold && !flush;
        e_idle     = (mq.size() == 0) && !m_hold;
        if (!m_hold && mq.size() > 0) begin
            e_pc = mq[0].pc;
            if (mq[0].excp) begin
                e_valid = 1; e_excp = 1; e_cause = mq[0].cause; e_tval = mq[0].pc;
            end else if (mq[0].data[1:0] != 2'b11) begin
                e_valid = 1; e_rvc = 1; e_inst = {16'h0, mq[0].data}; e_pop = 1;
            end else if (mq.size() >= 2) begin
                e_valid = 1;
                if (mq[1].excp) begin
                    e_excp = 1; e_cause = mq[1].cause; e_tval = mq[1].pc;
                end else begin
                    e_inst = {mq[1].data, mq[0].data}; e_pop = 2;
                end
            end
        end
    endtask

    task automatic drive(input bit v, input logic [38:0] pc, input logic [31:0] d,
                         input bit ev, input logic [3:0] ec, input bit ordy, input bit fl);
        @(negedge clk);
        in_valid = v; in_pc = pc; in_data = d;
        in_excp_valid = ev; in_excp_cause = ec;
        out_ready = ordy; flush = fl;
        #1;
        model_expect();
        check("in_ready", 64'(in_ready), 64'(e_in_ready));
        if (!fl) begin
            check("out_valid", 64'(out_valid), 64'(e_valid));
            check("align_idle", 64'(align_idle), 64'(e_idle));
            if (e_valid) begin
                check("out_pc", 64'(out_pc), 64'(e_pc));
                check("out_excp_valid", 64'(out_excp_valid), 64'(e_excp));
                if (e_excp) begin
                    check("out_excp_cause", 64'(out_excp_cause), 64'(e_cause));
                    check("out_excp_tval", 64'(out_excp_tval), 64'(e_tval));
                end else begin
                    check("out_inst", 64'(out_inst), 64'(e_inst));
                    check("out_is_rvc", 64'(out_is_rvc), 64'(e_rvc));
                end
            end
        end
    endtask

    task automatic tick();
        logic [38:0] base;
        @(posedge clk);
        if (flush) begin
            mq.delete();
            m_hold = 1'b0;
        end else begin
            if (e_valid && out_ready) begin
                if (e_excp) m_hold = 1'b1;
                else repeat (e_pop) void'(mq.pop_front());
            end
            if (in_valid && e_in_ready) begin
                base = {in_pc[38:2], 2'b00};
                if (!in_pc[1]) mq.push_back('{in_data[15:0], in_excp_valid, in_excp_cause, base});
                mq.push_back('{in_data[31:16], in_excp_valid, in_excp_cause, base + 39'd2});
            end
        end
    endtask

    task automatic step(input bit v, input logic [38:0] pc, input logic [31:0] d,
                        input bit ev, input logic [3:0] ec, input bit ordy, input bit fl);
        drive(v, pc, d, ev, ec, ordy, fl);
        tick();
    endtask

    logic [38:0] fpc;
    bit          r_fl, r_v, r_ordy, r_ev;

    initial begin
        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_idle", 64'(align_idle), 64'd1);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Mixed RVC / 32-bit
        drive(1, 39'h1000, 32'h0001_4501, 0, 0, 1, 0);
        check("mix_first_latency", 64'(out_valid), 64'd0);
        tick();
        drive(1, 39'h1004, 32'h0000_0513, 0, 0, 1, 0);
        check("mix0_inst", 64'(out_inst), 64'h4501);
        check("mix0_pc", 64'(out_pc), 64'h1000);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        check("mix1_inst", 64'(out_inst), 64'h0001);
        check("mix1_pc", 64'(out_pc), 64'h1002);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        check("mix2_inst", 64'(out_inst), 64'h0000_0513);
        check("mix2_pc", 64'(out_pc), 64'h1004);
        check("mix2_rvc", 64'(out_is_rvc), 64'd0);
        tick();
        step(0, 0, 0, 0, 0, 1, 0);

        // Straddling 32-bit instruction
        step(1, 39'h2000, 32'h0513_4501, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        check("str0_pc", 64'(out_pc), 64'h2000);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        check("str_stall", 64'(out_valid), 64'd0);
        tick();
        step(1, 39'h2004, 32'h4501_0000, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        check("str1_inst", 64'(out_inst), 64'h0000_0513);
        check("str1_pc", 64'(out_pc), 64'h2002);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        check("str2_pc", 64'(out_pc), 64'h2006);
        check("str2_inst", 64'(out_inst), 64'h4501);
        tick();

        // Odd entry point
        step(0, 0, 0, 0, 0, 1, 1);
        step(1, 39'h3002, 32'h4501_1234, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        check("odd_pc", 64'(out_pc), 64'h3002);
        check("odd_inst", 64'(out_inst), 64'h4501);
        tick();
        step(1, 39'h3004, 32'h0000_4501, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        check("odd_next_pc", 64'(out_pc), 64'h3004);
        tick();

        // Fault on the upper half of a 32-bit instruction
        step(0, 0, 0, 0, 0, 1, 1);
        step(1, 39'h4000, 32'h0513_4501, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        drive(1, 39'h4004, 32'h1234_5678, 1, 4'd12, 1, 0);
        check("split_stall", 64'(out_valid), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        check("split_excp", 64'(out_excp_valid), 64'd1);
        check("split_pc", 64'(out_pc), 64'h4002);
        check("split_tval", 64'(out_excp_tval), 64'h4004);
        check("split_cause", 64'(out_excp_cause), 64'd12);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 39'h4008, 32'h0, 0, 0, 1, 0);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd0);
            tick();
        end

        // Backpressure with a full queue, then flush
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 39'h6000, 32'h4501_4501, 0, 0, 0, 0);
        step(1, 39'h6004, 32'h4501_4501, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 39'h6008, 32'h4501_4501, 0, 0, 0, 0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_pc", 64'(out_pc), 64'h6000);
            tick();
        end
        drive(1, 39'h7000, 32'h4501_4501, 0, 0, 1, 1);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        check("post_flush_valid", 64'(out_valid), 64'd0);
        check("post_flush_idle", 64'(align_idle), 64'd1);
        tick();

        // Asynchronous reset with three parcels held
        step(1, 39'h5002, 32'h4501_0000, 0, 0, 0, 0);
        step(1, 39'h5004, 32'h0513_4501, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_pc", 64'(out_pc), 64'd0);
        mq.delete();
        m_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 0);
        check("arst_idle", 64'(align_idle), 64'd1);
        check("arst_no_pulse", 64'(out_valid), 64'd0);
        tick();

        // Random stream
        fpc = 39'h8000;
        for (int n = 0; n < 3000; n++) begin
            r_fl   = $urandom_range(0, 99) < (m_hold ? 30 : 3);
            r_v    = $urandom_range(0, 3) != 0;
            r_ordy = $urandom_range(0, 3) != 0;
            r_ev   = $urandom_range(0, 99) < 4;
            drive(r_v, fpc, $urandom(), r_ev, 4'($urandom_range(0, 15)), r_ordy, r_fl);
            tick();
            if (r_fl) begin
                if ($urandom_range(0, 3) == 0)
                    fpc = 39'h7F_FFFF_FFFF - 39'(2 * $urandom_range(0, 7));
                else
                    fpc = 39'({$urandom(), $urandom()});
                fpc[0] = 1'b0;
            end else if (r_v && e_in_ready) begin
                fpc = {fpc[38:2], 2'b00} + 39'd4;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
